piso_frame_ctrl: RTL and testbench

PISO_FRAME_CTRL -- requirements
Module: piso_frame_ctrl

---
 rtl/piso_frame_ctrl.sv | 142 ++++++++++++++
 tb/tb_piso_frame_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/piso_frame_ctrl.sv
// Framed nibble serializer: START, 4 data bits MSB first, optional even parity, STOP.
// Define PISO_FRAME_PARITY_EN to compile in the PAR state and parity bit.
module piso_frame_ctrl #(
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    input  logic [3:0] in_data,
    output logic       in_ready,
    output logic       sdo,
    output logic       sel,
    output logic       busy,
    output logic       frame_done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
`ifdef PISO_FRAME_PARITY_EN
        PAR   = 3'd3,
`endif
        STOP  = 3'd4
    } state_t;

    localparam logic [7:0] CNT_LAST = 8'(BIT_CYCLES - 1);

    state_t     state_q, state_d;
    logic [3:0] shift_q, shift_d;
    logic [1:0] bidx_q, bidx_d;
    logic [7:0] cnt_q, cnt_d;
    logic       sdo_q, sdo_d;
    logic       sel_q, sel_d;
    logic       done_q, done_d;
    logic       bit_end;
`ifdef PISO_FRAME_PARITY_EN
    logic       par_q, par_d;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            shift_q <= 4'd0;
            bidx_q  <= 2'd0;
            cnt_q   <= 8'd0;
            sdo_q   <= 1'b1;
            sel_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef PISO_FRAME_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            bidx_q  <= bidx_d;
            cnt_q   <= cnt_d;
            sdo_q   <= sdo_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
`ifdef PISO_FRAME_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bit_end = (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        bidx_d  = bidx_q;
        cnt_d   = cnt_q;
        sel_d   = 1'b0;
        done_d  = 1'b0;
`ifdef PISO_FRAME_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != IDLE) begin
            cnt_d = bit_end ? 8'd0 : cnt_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (in_valid) begin
                    shift_d = in_data;
                    sel_d   = 1'b1;
                    state_d = START;
`ifdef PISO_FRAME_PARITY_EN
                    par_d   = ^in_data;
`endif
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d = {shift_q[2:0], 1'b0};
                    bidx_d  = bidx_q + 2'd1;
                    if (bidx_q == 2'd3) begin
`ifdef PISO_FRAME_PARITY_EN
                        state_d = PAR;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef PISO_FRAME_PARITY_EN
            PAR: begin
                if (bit_end) state_d = STOP;
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // The line is decoded from the next state so it changes on the same edge as the state.
        case (state_d)
            START:   sdo_d = 1'b0;
            DATA:    sdo_d = shift_d[3];
`ifdef PISO_FRAME_PARITY_EN
            PAR:     sdo_d = par_q;
`endif
            default: sdo_d = 1'b1;
        endcase
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign sdo        = sdo_q;
    assign sel        = sel_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_piso_frame_ctrl.sv
// Directed bench for piso_frame_ctrl: one instance at BIT_CYCLES=1, one at BIT_CYCLES=4.
// Expected line patterns follow the PISO_FRAME_PARITY_EN setting of the build.
module tb_piso_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       v1, v4;
    logic [3:0] d1, d4;
    logic       rdy1, sdo1, sel1, busy1, done1;
    logic       rdy4, sdo4, sel4, busy4, done4;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef PISO_FRAME_PARITY_EN
    localparam int L = 7;
    localparam logic [6:0] LN_1011 = 7'b0101111;
    localparam logic [6:0] LN_F    = 7'b0111101;
    localparam logic [6:0] LN_0    = 7'b0000001;
    localparam logic [6:0] LN_1001 = 7'b0100101;
    localparam logic [6:0] LN_1101 = 7'b0110111;
    localparam logic [6:0] LN_0110 = 7'b0011001;
`else
    localparam int L = 6;
    localparam logic [6:0] LN_1011 = 7'b0010111;
    localparam logic [6:0] LN_F    = 7'b0011111;
    localparam logic [6:0] LN_0    = 7'b0000001;
    localparam logic [6:0] LN_1001 = 7'b0010011;
    localparam logic [6:0] LN_1101 = 7'b0011011;
    localparam logic [6:0] LN_0110 = 7'b0001101;
`endif

    always #5 clk = ~clk;

    piso_frame_ctrl #(.BIT_CYCLES(1)) u_dut1 (
        .clk(clk), .reset_n(rst_n), .in_valid(v1), .in_data(d1),
        .in_ready(rdy1), .sdo(sdo1), .sel(sel1), .busy(busy1), .frame_done(done1)
    );

    piso_frame_ctrl #(.BIT_CYCLES(4)) u_dut4 (
        .clk(clk), .reset_n(rst_n), .in_valid(v4), .in_data(d4),
        .in_ready(rdy4), .sdo(sdo4), .sel(sel4), .busy(busy4), .frame_done(done4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_ready1();
        int k = 0;
        @(negedge clk);
        while (!rdy1 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("rdy1_wait", 32'(rdy1), 32'd1);
    endtask

    // One frame on the BIT_CYCLES=1 instance; meddle keeps in_valid high and changes in_data mid-frame.
    task automatic frame1(input logic [3:0] nib, input logic [6:0] line, input bit meddle);
        wait_ready1();
        v1 = 1'b1;
        d1 = nib;
        @(posedge clk);
        #1;
        if (!meddle) v1 = 1'b0;
        for (int i = 1; i <= L; i++) begin
            @(negedge clk);
            check($sformatf("sdo1 %h c%0d", nib, i), 32'(sdo1), 32'(line[L-i]));
            check($sformatf("sel1 %h c%0d", nib, i), 32'(sel1), 32'(i == 1));
            check($sformatf("busy1 %h c%0d", nib, i), 32'(busy1), 32'd1);
            check($sformatf("rdy1 %h c%0d", nib, i), 32'(rdy1), 32'd0);
            check($sformatf("done1 %h c%0d", nib, i), 32'(done1), 32'd0);
            if (meddle && i == 2) d1 = ~nib;
            if (meddle && i == L) v1 = 1'b0;
        end
        @(negedge clk);
        check($sformatf("done1 %h end", nib), 32'(done1), 32'd1);
        check($sformatf("sdo1 %h end", nib), 32'(sdo1), 32'd1);
        check($sformatf("rdy1 %h end", nib), 32'(rdy1), 32'd1);
        check($sformatf("busy1 %h end", nib), 32'(busy1), 32'd0);
        check($sformatf("sel1 %h end", nib), 32'(sel1), 32'd0);
        @(negedge clk);
        check($sformatf("done1 %h after", nib), 32'(done1), 32'd0);
        $display("[TB] frame nibble=%h meddle=%0d checked", nib, meddle);
    endtask

    initial begin
        logic seen_done;
        logic exp_b;
        rst_n = 1'b0;
        v1 = 1'b0; d1 = 4'h0;
        v4 = 1'b0; d4 = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst sdo1", 32'(sdo1), 32'd1);
        check("rst sel1", 32'(sel1), 32'd0);
        check("rst busy1", 32'(busy1), 32'd0);
        check("rst done1", 32'(done1), 32'd0);
        check("rst rdy1", 32'(rdy1), 32'd1);
        check("rst sdo4", 32'(sdo4), 32'd1);
        check("rst rdy4", 32'(rdy4), 32'd1);
        rst_n = 1'b1;

        frame1(4'b1011, LN_1011, 1'b0);

        // Back-to-back: in_valid stays high, second handshake lands in the frame_done cycle.
        wait_ready1();
        v1 = 1'b1;
        d1 = 4'hF;
        @(posedge clk);
        #1;
        d1 = 4'h0;
        for (int i = 1; i <= 2 * L + 2; i++) begin
            @(negedge clk);
            if (i <= L)              exp_b = LN_F[L-i];
            else if (i == L + 1)     exp_b = 1'b1;
            else if (i <= 2 * L + 1) exp_b = LN_0[2*L+1-i];
            else                     exp_b = 1'b1;
            check($sformatf("b2b sdo c%0d", i), 32'(sdo1), 32'(exp_b));
            check($sformatf("b2b done c%0d", i), 32'(done1), 32'(i == L + 1 || i == 2 * L + 2));
            check($sformatf("b2b sel c%0d", i), 32'(sel1), 32'(i == 1 || i == L + 2));
            if (i == L + 1) begin
                @(posedge clk);
                #1;
                v1 = 1'b0;
            end
        end
        $display("[TB] back-to-back frames F,0 checked");

        frame1(4'b1001, LN_1001, 1'b1);

        // Reset pulsed during DATA bit index 2 (cycle 4 carries in_data[1]).
        wait_ready1();
        v1 = 1'b1;
        d1 = 4'b1101;
        @(posedge clk);
        #1;
        v1 = 1'b0;
        repeat (4) @(negedge clk);
        check("pre-rst sdo1", 32'(sdo1), 32'd0);
        check("pre-rst busy1", 32'(busy1), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("async sdo1", 32'(sdo1), 32'd1);
        check("async busy1", 32'(busy1), 32'd0);
        check("async rdy1", 32'(rdy1), 32'd1);
        check("async sel1", 32'(sel1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            seen_done = seen_done | done1;
        end
        check("no done after rst", 32'(seen_done), 32'd0);
        $display("[TB] mid-frame reset checked");
        frame1(4'b1101, LN_1101, 1'b0);

        // BIT_CYCLES=4 instance: every line level held for 4 clocks.
        v4 = 1'b1;
        d4 = 4'b0110;
        @(posedge clk);
        #1;
        v4 = 1'b0;
        for (int i = 1; i <= 4 * L; i++) begin
            @(negedge clk);
            check($sformatf("sdo4 c%0d", i), 32'(sdo4), 32'(LN_0110[L-1-(i-1)/4]));
            check($sformatf("busy4 c%0d", i), 32'(busy4), 32'd1);
            check($sformatf("done4 c%0d", i), 32'(done4), 32'd0);
            check($sformatf("sel4 c%0d", i), 32'(sel4), 32'(i == 1));
        end
        @(negedge clk);
        check("done4 end", 32'(done4), 32'd1);
        check("busy4 end", 32'(busy4), 32'd0);
        check("sdo4 end", 32'(sdo4), 32'd1);
        $display("[TB] BIT_CYCLES=4 frame nibble=6 checked");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
